tick_sample_sequencer: RTL and testbench

TICK_SAMPLE_SEQUENCER -- requirements
Module: tick_sample_sequencer

---
 rtl/tick_sample_sequencer.sv | 93 +++++++++
 tb/tb_tick_sample_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tick_sample_sequencer.sv
// tick_sample_sequencer: periodic tick generator driving a masked multi-channel sampling sequence on a shared ADC
// Ports:
//   clk_i, reset_ni                  clock, asynchronous active-low reset
//   enable_i, period_i               tick enable and period minus one (clk_i cycles)
//   ch_mask_i                        channels sampled on each accepted tick
//   clear_i                          clears overrun_o / timeout_o
//   tick_o                           one-cycle tick pulse
//   adc_start_o, adc_busy_i          conversion request / ADC not ready
//   adc_done_i, adc_data_i           conversion-complete strobe and result
//   sample_o, sample_ch_o            registered sample and its channel
//   sample_valid_o                   one-cycle strobe for sample_o / sample_ch_o
//   seq_busy_o                       sequence in progress
//   overrun_o, timeout_o             sticky error flags
module tick_sample_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1023,
    parameter int DATA_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      enable_i,
    input  logic [23:0]               period_i,
    input  logic [NUM_CH-1:0]         ch_mask_i,
    input  logic                      clear_i,
    output logic                      tick_o,
    output logic                      adc_start_o,
    input  logic                      adc_busy_i,
    input  logic                      adc_done_i,
    input  logic [DATA_W-1:0]         adc_data_i,
    output logic [DATA_W-1:0]         sample_o,
    output logic [$clog2(NUM_CH)-1:0] sample_ch_o,
    output logic                      sample_valid_o,
    output logic                      seq_busy_o,
    output logic                      overrun_o,
    output logic                      timeout_o
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SELECT, START, WAIT} state_t;
    state_t              state, state_nx;
    logic [23:0]         cnt;
    logic [NUM_CH-1:0]   pending, rest;
    logic [CH_W-1:0]     cur_ch, low_ch;
    logic [TO_W-1:0]     wait_cnt;
    logic                done_ev, to_ev;
    // >= rather than == so a period lowered below the running count wraps at once
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) cnt <= '0;
        else cnt <= (!enable_i || cnt >= period_i) ? '0 : cnt + 24'd1;
    // gated by reset so the tick is also silent while reset is held
    assign tick_o     = reset_ni && enable_i && cnt == '0;
    assign seq_busy_o = state != IDLE;
    always_comb begin
        low_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (pending[k]) low_ch = CH_W'(k);
        rest        = pending & ~(NUM_CH'(1) << cur_ch);
        done_ev     = state == WAIT && adc_done_i;
        to_ev       = state == WAIT && !adc_done_i && wait_cnt == TO_W'(TIMEOUT - 1);
        adc_start_o = state == START && !adc_busy_i;
        state_nx    = state;
        case (state)
            IDLE:    if (tick_o && ch_mask_i != '0) state_nx = SELECT;
            SELECT:  state_nx = START;
            START:   if (!adc_busy_i) state_nx = WAIT;
            WAIT:    if (done_ev || to_ev) state_nx = rest != '0 ? SELECT : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            state          <= IDLE;
            pending        <= '0;
            cur_ch         <= '0;
            wait_cnt       <= '0;
            sample_o       <= '0;
            sample_ch_o    <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            state          <= state_nx;
            pending        <= (state == IDLE && tick_o) ? ch_mask_i :
                              (done_ev || to_ev) ? rest : pending;
            cur_ch         <= state == SELECT ? low_ch : cur_ch;
            wait_cnt       <= state == WAIT ? wait_cnt + TO_W'(1) : '0;
            sample_valid_o <= done_ev;
            sample_o       <= done_ev ? adc_data_i : sample_o;
            sample_ch_o    <= done_ev ? cur_ch : sample_ch_o;
            overrun_o      <= (tick_o && state != IDLE) || (overrun_o && !clear_i);
            timeout_o      <= to_ev || (timeout_o && !clear_i);
        end
endmodule

// File: tb/tb_tick_sample_sequencer.sv
// tb_tick_sample_sequencer: directed self-checking bench for tick_sample_sequencer
module tb_tick_sample_sequencer;
    logic        clk_i = 1'b0, reset_ni = 1'b0, enable_i = 1'b0, clear_i = 1'b0;
    logic [23:0] period_i = '0;
    logic [3:0]  ch_mask_i = '0;
    logic        tick_o, adc_start_o, adc_busy_i = 1'b0, adc_done_i = 1'b0;
    logic [15:0] adc_data_i = '0, sample_o;
    logic [1:0]  sample_ch_o;
    logic        sample_valid_o, seq_busy_o, overrun_o, timeout_o;
    int          n_vec = 0, n_bad = 0, n_start = 0, n_valid = 0, s0, v0;
    logic [31:0] ticks;
    tick_sample_sequencer #(.NUM_CH(4), .TIMEOUT(8), .DATA_W(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .period_i(period_i),
        .ch_mask_i(ch_mask_i), .clear_i(clear_i), .tick_o(tick_o), .adc_start_o(adc_start_o),
        .adc_busy_i(adc_busy_i), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
        .sample_o(sample_o), .sample_ch_o(sample_ch_o), .sample_valid_o(sample_valid_o),
        .seq_busy_o(seq_busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );
    always #5 clk_i = ~clk_i;
    always @(negedge clk_i) begin
        if (adc_start_o) n_start++;
        if (sample_valid_o) n_valid++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask
    task automatic wait_start(input string tag);
        for (int i = 0; i < 40 && adc_start_o !== 1'b1; i++) cyc();
        check(tag, 32'(adc_start_o), 1);
    endtask
    task automatic do_conv(input string tag, input logic [15:0] data, input logic [1:0] ch);
        wait_start({tag, "_start"});
        repeat (5) cyc();
        adc_data_i = data;
        adc_done_i = 1'b1;
        cyc();
        adc_done_i = 1'b0;
        check({tag, "_valid"}, 32'(sample_valid_o), 1);
        check({tag, "_data"}, 32'(sample_o), 32'(data));
        check({tag, "_ch"}, 32'(sample_ch_o), 32'(ch));
    endtask
    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, 32'(tick_o), 0);
        check({tag, "_start"}, 32'(adc_start_o), 0);
        check({tag, "_sample"}, 32'(sample_o), 0);
        check({tag, "_ch"}, 32'(sample_ch_o), 0);
        check({tag, "_valid"}, 32'(sample_valid_o), 0);
        check({tag, "_busy"}, 32'(seq_busy_o), 0);
        check({tag, "_ovr"}, 32'(overrun_o), 0);
        check({tag, "_tmo"}, 32'(timeout_o), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        repeat (3) cyc();
        check_all_zero("reset");
        reset_ni = 1'b1;
        cyc();
        // tick spacing with period 9, empty mask
        period_i = 24'd9;
        s0 = n_start;
        enable_i = 1'b1;
        #1;
        ticks = '0;
        ticks[0] = tick_o;
        for (int c = 1; c < 30; c++) begin
            cyc();
            ticks[c] = tick_o;
        end
        check("tick_pattern", ticks, 32'h0010_0401);
        check("no_start_mask0", 32'(n_start - s0), 0);
        check("idle_mask0", 32'(seq_busy_o), 0);
        enable_i = 1'b0;
        cyc();
        // lowering period below the running count wraps immediately
        enable_i = 1'b1;
        repeat (6) cyc();
        check("cnt6_notick", 32'(tick_o), 0);
        period_i = 24'd2;
        cyc();
        check("lowered_wrap_tick", 32'(tick_o), 1);
        cyc();
        check("after_wrap_notick", 32'(tick_o), 0);
        enable_i = 1'b0;
        cyc();
        // two-channel sequence, mask 1010
        period_i = 24'd1000;
        ch_mask_i = 4'b1010;
        enable_i = 1'b1;
        #1;
        do_conv("seq_ch1", 16'h1234, 2'd1);
        ch_mask_i = 4'b0001;
        do_conv("seq_ch3", 16'h5678, 2'd3);
        check("seq_done_idle", 32'(seq_busy_o), 0);
        cyc();
        check("valid_one_cycle", 32'(sample_valid_o), 0);
        enable_i = 1'b0;
        cyc();
        // ADC busy for 7 cycles while in START
        ch_mask_i = 4'b0001;
        adc_busy_i = 1'b1;
        s0 = n_start;
        enable_i = 1'b1;
        #1;
        repeat (9) cyc();
        check("busy_no_start", 32'(n_start - s0), 0);
        check("busy_still_seq", 32'(seq_busy_o), 1);
        adc_busy_i = 1'b0;
        #1;
        check("start_after_busy", 32'(adc_start_o), 1);
        do_conv("busy_conv", 16'hBEEF, 2'd0);
        check("busy_one_start", 32'(n_start - s0), 1);
        enable_i = 1'b0;
        cyc();
        // timeout on channel 0, channel 1 proceeds
        ch_mask_i = 4'b0011;
        s0 = n_start;
        v0 = n_valid;
        enable_i = 1'b1;
        #1;
        repeat (10) cyc();
        check("tmo_not_yet", 32'(timeout_o), 0);
        cyc();
        check("tmo_set", 32'(timeout_o), 1);
        check("tmo_no_valid", 32'(n_valid - v0), 0);
        do_conv("tmo_next", 16'h0ABC, 2'd1);
        check("tmo_starts", 32'(n_start - s0), 2);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        check("tmo_cleared", 32'(timeout_o), 0);
        enable_i = 1'b0;
        cyc();
        // overrun with period 3 and slow ADC
        period_i = 24'd3;
        ch_mask_i = 4'b1111;
        enable_i = 1'b1;
        #1;
        repeat (4) cyc();
        check("ovr_tick4", 32'(tick_o), 1);
        check("ovr_not_yet", 32'(overrun_o), 0);
        cyc();
        check("ovr_set", 32'(overrun_o), 1);
        clear_i = 1'b1;
        cyc();
        check("ovr_cleared", 32'(overrun_o), 0);
        repeat (3) cyc();
        clear_i = 1'b0;
        check("ovr_set_wins", 32'(overrun_o), 1);
        check("ovr_in_wait", 32'(seq_busy_o), 1);
        // asynchronous reset while waiting for a conversion
        reset_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        enable_i = 1'b0;
        cyc();
        reset_ni = 1'b1;
        adc_data_i = 16'hDEAD;
        adc_done_i = 1'b1;
        cyc();
        adc_done_i = 1'b0;
        check("late_done_valid", 32'(sample_valid_o), 0);
        check("late_done_sample", 32'(sample_o), 0);
        check("late_done_busy", 32'(seq_busy_o), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
